// File: rtl/dual_stream_align.sv
// dual_stream_align: writes two pixel streams into circular buffers from SOF
// and pops them in lockstep so pixel n of A and pixel n of B leave together.
module dual_stream_align #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                  iclk,
    input  logic                  rst_i,
    input  logic                  a_vld_i,
    input  logic                  a_sof_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  b_vld_i,
    input  logic                  b_sof_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  vld_o,
    output logic                  sof_o,
    output logic [DATA_WIDTH-1:0] a_data_o,
    output logic [DATA_WIDTH-1:0] b_data_o,
    output logic                  locked_o,
    output logic                  ovf_o,
    output logic                  err_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int EW    = DATA_WIDTH + 1;

    typedef enum logic {SEEK, RUN} state_t;

    state_t state, state_nx;

    logic [EW-1:0] mem_a [DEPTH];
    logic [EW-1:0] mem_b [DEPTH];

    logic [ADDR_W:0] wr_a, rd_a, wr_b, rd_b;
    logic            arm_a, arm_b;

    logic [EW-1:0] ha_q, hb_q;
    logic          hv_q;

    logic empty_a, empty_b, full_a, full_b;
    logic we_a, we_b, pop_raw, pop;
    logic ovf_ev, mis, flush;

    // Buffer status, write/pop qualification and flush causes.
    always_comb begin
        empty_a = (wr_a == rd_a);
        empty_b = (wr_b == rd_b);
        full_a  = (wr_a[ADDR_W-1:0] == rd_a[ADDR_W-1:0])
                  && (wr_a[ADDR_W] != rd_a[ADDR_W]);
        full_b  = (wr_b[ADDR_W-1:0] == rd_b[ADDR_W-1:0])
                  && (wr_b[ADDR_W] != rd_b[ADDR_W]);
        we_a    = a_vld_i && (arm_a || a_sof_i);
        we_b    = b_vld_i && (arm_b || b_sof_i);
        pop_raw = !empty_a && !empty_b;
        // a pop in the same cycle frees the slot, so a full write is legal then
        ovf_ev  = ((we_a && full_a) || (we_b && full_b)) && !pop_raw;
        mis     = hv_q && (ha_q[DATA_WIDTH] != hb_q[DATA_WIDTH]);
        flush   = ovf_ev || mis;
        pop     = pop_raw && !flush;
    end

    // Next-state logic: lock once both heads exist, drop back on any flush.
    always_comb begin
        state_nx = state;
        unique case (state)
            SEEK: if (!flush && pop_raw) state_nx = RUN;
            RUN:  if (flush) state_nx = SEEK;
            default: state_nx = SEEK;
        endcase
    end

    // State register.
    always_ff @(posedge iclk) begin
        if (rst_i) state <= SEEK;
        else       state <= state_nx;
    end

    // Buffer storage and registered head read; read-before-write on a shared slot.
    always_ff @(posedge iclk) begin
        if (we_a && !flush) mem_a[wr_a[ADDR_W-1:0]] <= {a_sof_i, a_data_i};
        if (we_b && !flush) mem_b[wr_b[ADDR_W-1:0]] <= {b_sof_i, b_data_i};
        if (pop) begin
            ha_q <= mem_a[rd_a[ADDR_W-1:0]];
            hb_q <= mem_b[rd_b[ADDR_W-1:0]];
        end
    end

    // Pointers, arm flags and head-valid; flush empties both buffers.
    always_ff @(posedge iclk) begin
        if (rst_i) begin
            wr_a  <= '0;
            rd_a  <= '0;
            wr_b  <= '0;
            rd_b  <= '0;
            arm_a <= 1'b0;
            arm_b <= 1'b0;
            hv_q  <= 1'b0;
        end else begin
            hv_q <= pop;
            if (flush) begin
                rd_a  <= wr_a;
                rd_b  <= wr_b;
                arm_a <= 1'b0;
                arm_b <= 1'b0;
            end else begin
                if (we_a) wr_a <= wr_a + 1'b1;
                if (we_b) wr_b <= wr_b + 1'b1;
                if (pop) begin
                    rd_a <= rd_a + 1'b1;
                    rd_b <= rd_b + 1'b1;
                end
                if (a_vld_i && a_sof_i) arm_a <= 1'b1;
                if (b_vld_i && b_sof_i) arm_b <= 1'b1;
            end
        end
    end

    // Registered outputs; data holds while no pair is emitted.
    always_ff @(posedge iclk) begin
        if (rst_i) begin
            vld_o    <= 1'b0;
            sof_o    <= 1'b0;
            a_data_o <= '0;
            b_data_o <= '0;
            locked_o <= 1'b0;
            ovf_o    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            vld_o    <= hv_q && !mis;
            sof_o    <= hv_q && !mis && ha_q[DATA_WIDTH];
            locked_o <= (state_nx == RUN);
            err_o    <= mis;
            if (ovf_ev) ovf_o <= 1'b1;
            if (hv_q && !mis) begin
                a_data_o <= ha_q[DATA_WIDTH-1:0];
                b_data_o <= hb_q[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_dual_stream_align.sv
// tb_dual_stream_align: scoreboard bench, expected pairs queued with the
// stimulus and compared as aligned pairs leave the selected instance.
module tb_dual_stream_align;

    localparam int DW = 8;

    typedef struct packed {
        logic          sof;
        logic [DW-1:0] d;
    } pix_t;

    typedef struct packed {
        logic          sof;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    logic          iclk = 1'b0;
    logic          rst_i;
    logic          a_vld_i, a_sof_i, b_vld_i, b_sof_i;
    logic [DW-1:0] a_data_i, b_data_i;

    logic          vld_o, sof_o, locked_o, ovf_o, err_o;
    logic [DW-1:0] a_data_o, b_data_o;
    logic          vld4, sof4, locked4, ovf4, err4;
    logic [DW-1:0] a4, b4;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_err = 0;
    int    t_sof_a, t_sof_b, t_first, err_cnt;
    bit    sel4 = 1'b0;
    pix_t  qa[$];
    pix_t  qb[$];
    pair_t qexp[$];

    logic          mv, ms, me;
    logic [DW-1:0] ma, mb;
    pair_t         e;

    dual_stream_align #(.DATA_WIDTH(DW), .ADDR_W(10)) dut (
        .iclk(iclk), .rst_i(rst_i),
        .a_vld_i(a_vld_i), .a_sof_i(a_sof_i), .a_data_i(a_data_i),
        .b_vld_i(b_vld_i), .b_sof_i(b_sof_i), .b_data_i(b_data_i),
        .vld_o(vld_o), .sof_o(sof_o),
        .a_data_o(a_data_o), .b_data_o(b_data_o),
        .locked_o(locked_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    dual_stream_align #(.DATA_WIDTH(DW), .ADDR_W(4)) dut4 (
        .iclk(iclk), .rst_i(rst_i),
        .a_vld_i(a_vld_i), .a_sof_i(a_sof_i), .a_data_i(a_data_i),
        .b_vld_i(b_vld_i), .b_sof_i(b_sof_i), .b_data_i(b_data_i),
        .vld_o(vld4), .sof_o(sof4),
        .a_data_o(a4), .b_data_o(b4),
        .locked_o(locked4), .ovf_o(ovf4), .err_o(err4)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: pop the scoreboard for every emitted pair.
    always @(negedge iclk) begin
        mv = sel4 ? vld4 : vld_o;
        ms = sel4 ? sof4 : sof_o;
        me = sel4 ? err4 : err_o;
        ma = sel4 ? a4 : a_data_o;
        mb = sel4 ? b4 : b_data_o;
        if (me === 1'b1) err_cnt++;
        if (mv === 1'b1) begin
            if (t_first < 0) t_first = cyc;
            if (qexp.size() == 0) begin
                check("extra_pair", 32'd1, 32'd0);
            end else begin
                e = qexp.pop_front();
                check("a_data", 32'(ma), 32'(e.a));
                check("b_data", 32'(mb), 32'(e.b));
                check("sof", 32'(ms), 32'(e.sof));
            end
        end
    end

    task automatic push_a(input int len, input int base);
        for (int i = 0; i < len; i++)
            qa.push_back('{sof: (i == 0), d: DW'(base + i)});
    endtask

    task automatic push_b(input int len, input int base);
        for (int i = 0; i < len; i++)
            qb.push_back('{sof: (i == 0), d: DW'(base + i)});
    endtask

    task automatic expect_pairs(input int len, input int a0, input int b0);
        for (int i = 0; i < len; i++)
            qexp.push_back('{sof: (i == 0), a: DW'(a0 + i), b: DW'(b0 + i)});
    endtask

    task automatic drv_a(input int lag, input int idle);
        pix_t p;
        repeat (lag) @(posedge iclk);
        while (qa.size() > 0) begin
            while (idle > 0 && int'($urandom_range(99)) < idle) begin
                @(posedge iclk); #1;
                a_vld_i = 1'b0;
            end
            @(posedge iclk); #1;
            p = qa.pop_front();
            a_vld_i  = 1'b1;
            a_sof_i  = p.sof;
            a_data_i = p.d;
            if (p.sof && t_sof_a < 0) t_sof_a = cyc;
        end
        @(posedge iclk); #1;
        a_vld_i = 1'b0;
        a_sof_i = 1'b0;
    endtask

    task automatic drv_b(input int lag, input int idle);
        pix_t p;
        repeat (lag) @(posedge iclk);
        while (qb.size() > 0) begin
            while (idle > 0 && int'($urandom_range(99)) < idle) begin
                @(posedge iclk); #1;
                b_vld_i = 1'b0;
            end
            @(posedge iclk); #1;
            p = qb.pop_front();
            b_vld_i  = 1'b1;
            b_sof_i  = p.sof;
            b_data_i = p.d;
            if (p.sof && t_sof_b < 0) t_sof_b = cyc;
        end
        @(posedge iclk); #1;
        b_vld_i = 1'b0;
        b_sof_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (20) @(posedge iclk);
        @(negedge iclk);
        check(tag, qexp.size(), 0);
        qexp.delete();
    endtask

    task automatic run(input int lag_a, input int lag_b, input int idle,
                       input string tag);
        t_sof_a = -1;
        t_sof_b = -1;
        t_first = -1;
        fork
            drv_a(lag_a, idle);
            drv_b(lag_b, idle);
        join
        drain(tag);
    endtask

    task automatic do_reset();
        @(posedge iclk); #1;
        rst_i = 1'b1;
        @(posedge iclk); #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i    = 1'b1;
        a_vld_i  = 1'b0;
        a_sof_i  = 1'b0;
        a_data_i = '0;
        b_vld_i  = 1'b0;
        b_sof_i  = 1'b0;
        b_data_i = '0;
        t_first  = -1;
        t_sof_a  = -1;
        t_sof_b  = -1;
        err_cnt  = 0;

        @(posedge iclk);
        @(negedge iclk);
        check("rst_vld", 32'(vld_o), 0);
        check("rst_sof", 32'(sof_o), 0);
        check("rst_locked", 32'(locked_o), 0);
        check("rst_ovf", 32'(ovf_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_a", 32'(a_data_o), 0);
        check("rst_b", 32'(b_data_o), 0);
        @(posedge iclk); #1;
        rst_i = 1'b0;

        // simultaneous SOFs, 16 back-to-back pixels
        push_a(16, 0);
        push_b(16, 100);
        expect_pairs(16, 0, 100);
        run(0, 0, 0, "t1_drain");
        check("t1_latency", t_first - t_sof_b, 3);
        check("t1_locked", 32'(locked_o), 1);

        // B lags A by 100 cycles, three 64-pixel frames
        do_reset();
        for (int f = 0; f < 3; f++) begin
            push_a(64, f * 64);
            push_b(64, 7 + f * 64);
            expect_pairs(64, f * 64, 7 + f * 64);
        end
        run(0, 100, 0, "t2_drain");
        check("t2_latency", t_first - t_sof_b, 3);
        check("t2_ovf", 32'(ovf_o), 0);

        // 16-deep buffers, 20-pixel skew overflows
        do_reset();
        sel4 = 1'b1;
        push_a(32, 0);
        push_b(32, 50);
        run(0, 20, 0, "t3_drain");
        check("t3_ovf", 32'(ovf4), 1);
        check("t3_locked", 32'(locked4), 0);
        push_a(8, 10);
        push_b(8, 60);
        expect_pairs(8, 10, 60);
        run(0, 0, 0, "t3_resume");
        check("t3_ovf_sticky", 32'(ovf4), 1);
        check("t3_relock", 32'(locked4), 1);
        sel4 = 1'b0;

        // A frame of 10 against B frame of 12
        do_reset();
        err_cnt = 0;
        push_a(10, 0);
        push_a(8, 30);
        push_b(12, 100);
        push_b(8, 130);
        expect_pairs(10, 0, 100);
        run(0, 0, 0, "t4_drain");
        check("t4_err", err_cnt, 1);
        check("t4_seek", 32'(locked_o), 0);
        push_a(8, 50);
        push_b(8, 150);
        expect_pairs(8, 50, 150);
        run(0, 0, 0, "t4_realign");
        check("t4_locked", 32'(locked_o), 1);
        check("t4_err_once", err_cnt, 1);

        // random gaps, two 256-pixel frames
        do_reset();
        err_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            push_a(256, f * 7);
            push_b(256, 3 + f * 11);
            expect_pairs(256, f * 7, 3 + f * 11);
        end
        run(0, 0, 30, "t5_drain");
        check("t5_err", err_cnt, 0);
        check("t5_ovf", 32'(ovf_o), 0);

        // reset pulse mid-frame while locked
        do_reset();
        push_a(32, 0);
        push_b(32, 100);
        expect_pairs(14, 0, 100);
        t_first = -1;
        fork
            drv_a(0, 0);
            drv_b(0, 0);
            begin
                repeat (17) @(posedge iclk);
                #1 rst_i = 1'b1;
                @(posedge iclk); #1;
                rst_i = 1'b0;
                @(negedge iclk);
                check("t6_vld", 32'(vld_o), 0);
                check("t6_sof", 32'(sof_o), 0);
                check("t6_a", 32'(a_data_o), 0);
                check("t6_b", 32'(b_data_o), 0);
                check("t6_locked", 32'(locked_o), 0);
                check("t6_err", 32'(err_o), 0);
            end
        join
        drain("t6_drain");
        push_a(8, 40);
        push_b(8, 140);
        expect_pairs(8, 40, 140);
        run(0, 0, 0, "t6_restart");
        check("t6_relock", 32'(locked_o), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
